// File: rtl/echo_rec_pkg.sv
// rtl/echo_rec_pkg.sv - shared state encodings and sizing helper for the echo window recorder
package echo_rec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_POST    = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_DONE    = 3'd4,
        ST_READ    = 3'd5
    } rec_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/echo_sample_ram.sv
// rtl/echo_sample_ram.sv - simple dual-port sample store with registered read port
module echo_sample_ram #(
    parameter int DATA_W = 8,
    parameter int WORDS  = 1536,
    parameter int ADDR_W = 11
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge adc_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read register only updates on i_re, so the output holds while the consumer stalls.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/echo_window_recorder.sv
// rtl/echo_window_recorder.sv - multi-channel pre/post-trigger echo capture with streamed readout
module echo_window_recorder
    import echo_rec_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  N_CH   = 6,
    parameter int  DEPTH  = 256,
    parameter int  TS_W   = 13,
    localparam int AW     = clog2(DEPTH),
    localparam int CH_W   = clog2(N_CH)
) (
    input  logic                     adc_clk,
    input  logic                     reset,
    input  logic                     i_arm,
    input  logic                     i_abort,
    input  logic [AW-1:0]            i_pre_len,
    input  logic [AW:0]              i_post_len,
    input  logic [7:0]               i_holdoff,
    input  logic [DATA_W-1:0]        i_sample,
    input  logic                     i_sample_valid,
    input  logic                     i_trig,
    input  logic                     i_rd_start,
    input  logic [CH_W-1:0]          i_rd_ch,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic                     o_rd_last,
    output logic [2:0]               o_state,
    output logic [N_CH-1:0]          o_ch_done,
    output logic [N_CH*TS_W-1:0]     o_ch_ts,
    output logic [N_CH*(AW+1)-1:0]   o_ch_len,
    output logic                     o_overflow
);

    localparam int              LW      = AW + 1;
    localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);
    localparam logic [TS_W-1:0] TS_MAX  = '1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

    rec_state_t      r_state;
    logic [CH_W-1:0] r_ch;
    logic [AW-1:0]   r_wptr;
    logic [LW-1:0]   r_fill;
    logic [TS_W-1:0] r_ts;
    logic [LW-1:0]   r_post_rem;
    logic [LW-1:0]   r_win_len;
    logic [7:0]      r_hold;
    logic [N_CH-1:0] r_ch_done;
    logic [TS_W-1:0] r_ch_ts    [N_CH];
    logic [LW-1:0]   r_ch_len   [N_CH];
    logic [AW-1:0]   r_ch_start [N_CH];
    logic            r_overflow;

    logic [CH_W-1:0] r_rd_ch;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_issue_rem;
    logic            r_rd_valid;
    logic            r_rd_last;

    logic [LW-1:0]   w_pre;
    logic [LW-1:0]   w_room;
    logic [LW-1:0]   w_post_eff;
    logic [LW-1:0]   w_post_first;
    logic [LW-1:0]   w_post_left;
    logic [AW-1:0]   w_start;
    logic [TS_W-1:0] w_ts_next;
    logic [7:0]      w_hold_load;
    logic            w_rd_ch_ok;
    logic            w_wr_en;
    logic            w_rd_issue;
    logic            w_rd_xfer;

    // The sample arriving with the trigger is the first post-trigger sample.
    always_comb begin
        w_pre        = ({1'b0, i_pre_len} < r_fill) ? {1'b0, i_pre_len} : r_fill;
        w_room       = DEPTH_L - w_pre;
        w_post_eff   = (i_post_len < w_room) ? i_post_len : w_room;
        w_post_first = (i_sample_valid && (w_post_eff != '0)) ? LW'(1) : '0;
        w_post_left  = w_post_eff - w_post_first;
        w_start      = r_wptr - w_pre[AW-1:0];
        w_ts_next    = (r_ts == TS_MAX) ? r_ts : r_ts + 1'b1;
        w_hold_load  = (i_holdoff == 8'd0) ? 8'd0 : i_holdoff - 8'd1;
        w_rd_ch_ok   = ({1'b0, i_rd_ch} < (CH_W + 1)'(N_CH));
        w_wr_en      = i_sample_valid && ((r_state == ST_ARMED) || (r_state == ST_POST));
        w_rd_xfer    = r_rd_valid && i_rd_ready;
        w_rd_issue   = (r_state == ST_READ) && (r_issue_rem != '0) && (!r_rd_valid || i_rd_ready);
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_wptr      <= '0;
            r_fill      <= '0;
            r_ts        <= '0;
            r_post_rem  <= '0;
            r_win_len   <= '0;
            r_hold      <= '0;
            r_ch_done   <= '0;
            r_overflow  <= 1'b0;
            r_rd_ch     <= '0;
            r_rptr      <= '0;
            r_issue_rem <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_ch_ts[c]    <= '0;
                r_ch_len[c]   <= '0;
                r_ch_start[c] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if ((r_state == ST_DONE) && i_trig) r_overflow <= 1'b1;
                    if (i_arm) begin
                        r_ch_done  <= '0;
                        r_overflow <= 1'b0;
                        r_ts       <= '0;
                        r_ch       <= '0;
                        r_wptr     <= '0;
                        r_fill     <= '0;
                        for (int c = 0; c < N_CH; c++) begin
                            r_ch_ts[c]  <= '0;
                            r_ch_len[c] <= '0;
                        end
                        r_state <= ST_ARMED;
                    end else if (i_rd_start && w_rd_ch_ok && r_ch_done[i_rd_ch]) begin
                        r_rd_ch     <= i_rd_ch;
                        r_rptr      <= r_ch_start[i_rd_ch];
                        r_issue_rem <= r_ch_len[i_rd_ch];
                        r_rd_valid  <= 1'b0;
                        r_rd_last   <= 1'b0;
                        r_state     <= ST_READ;
                    end
                end

                ST_ARMED: begin
                    r_ts <= w_ts_next;
                    if (i_abort) begin
                        r_state <= ST_DONE;
                    end else begin
                        if (i_sample_valid) begin
                            r_wptr <= r_wptr + 1'b1;
                            if (r_fill != DEPTH_L) r_fill <= r_fill + 1'b1;
                        end
                        if (i_trig) begin
                            r_ch_ts[r_ch]    <= r_ts;
                            r_ch_start[r_ch] <= w_start;
                            r_win_len        <= w_pre + w_post_eff;
                            if (w_post_left == '0) begin
                                r_ch_done[r_ch] <= 1'b1;
                                r_ch_len[r_ch]  <= w_pre + w_post_eff;
                                r_hold          <= w_hold_load;
                                r_state         <= ST_HOLDOFF;
                            end else begin
                                r_post_rem <= w_post_left;
                                r_state    <= ST_POST;
                            end
                        end
                    end
                end

                ST_POST: begin
                    r_ts <= w_ts_next;
                    if (i_abort) begin
                        r_state <= ST_DONE;
                    end else if (i_sample_valid) begin
                        r_wptr     <= r_wptr + 1'b1;
                        r_post_rem <= r_post_rem - 1'b1;
                        if (r_post_rem == LW'(1)) begin
                            r_ch_done[r_ch] <= 1'b1;
                            r_ch_len[r_ch]  <= r_win_len;
                            r_hold          <= w_hold_load;
                            r_state         <= ST_HOLDOFF;
                        end
                    end
                end

                ST_HOLDOFF: begin
                    r_ts <= w_ts_next;
                    if (i_abort) begin
                        r_state <= ST_DONE;
                    end else if (r_hold == 8'd0) begin
                        if (r_ch == CH_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_ch    <= r_ch + 1'b1;
                            r_wptr  <= '0;
                            r_fill  <= '0;
                            r_state <= ST_ARMED;
                        end
                    end else begin
                        r_hold <= r_hold - 8'd1;
                    end
                end

                ST_READ: begin
                    if (w_rd_issue) begin
                        r_rptr      <= r_rptr + 1'b1;
                        r_issue_rem <= r_issue_rem - 1'b1;
                        r_rd_valid  <= 1'b1;
                        r_rd_last   <= (r_issue_rem == LW'(1));
                    end else if (w_rd_xfer) begin
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                    end
                    // A zero-length window has nothing to stream and returns at once.
                    if ((w_rd_xfer && r_rd_last) || ((r_issue_rem == '0) && !r_rd_valid)) begin
                        r_state <= ST_DONE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    echo_sample_ram #(
        .DATA_W (DATA_W),
        .WORDS  (N_CH * DEPTH),
        .ADDR_W (CH_W + AW)
    ) u_ram (
        .adc_clk (adc_clk),
        .reset   (reset),
        .i_we    (w_wr_en),
        .i_waddr ({r_ch, r_wptr}),
        .i_wdata (i_sample),
        .i_re    (w_rd_issue),
        .i_raddr ({r_rd_ch, r_rptr}),
        .o_rdata (o_rd_data)
    );

    assign o_rd_valid = r_rd_valid;
    assign o_rd_last  = r_rd_last;
    assign o_state    = r_state;
    assign o_ch_done  = r_ch_done;
    assign o_overflow = r_overflow;

    for (genvar c = 0; c < N_CH; c++) begin : g_status
        assign o_ch_ts[c*TS_W +: TS_W] = r_ch_ts[c];
        assign o_ch_len[c*LW +: LW]    = r_ch_len[c];
    end

endmodule

// File: tb/tb_echo_window_recorder.sv
// tb/tb_echo_window_recorder.sv - scoreboard bench for the echo window recorder
module tb_echo_window_recorder;
    import echo_rec_pkg::*;

    localparam int DATA_W = 8;
    localparam int N_CH   = 6;
    localparam int DEPTH  = 256;
    localparam int TS_W   = 13;
    localparam int AW     = 8;
    localparam int LW     = 9;
    localparam int CH_W   = 3;

    logic                   adc_clk = 1'b0;
    logic                   reset;
    logic                   i_arm, i_abort, i_sample_valid, i_trig, i_rd_start, i_rd_ready;
    logic [AW-1:0]          i_pre_len;
    logic [AW:0]            i_post_len;
    logic [7:0]             i_holdoff;
    logic [DATA_W-1:0]      i_sample;
    logic [CH_W-1:0]        i_rd_ch;
    logic [DATA_W-1:0]      o_rd_data;
    logic                   o_rd_valid, o_rd_last, o_overflow;
    logic [2:0]             o_state;
    logic [N_CH-1:0]        o_ch_done;
    logic [N_CH*TS_W-1:0]   o_ch_ts;
    logic [N_CH*LW-1:0]     o_ch_len;

    always #5 adc_clk = ~adc_clk;

    echo_window_recorder #(
        .DATA_W (DATA_W), .N_CH (N_CH), .DEPTH (DEPTH), .TS_W (TS_W)
    ) dut (
        .adc_clk        (adc_clk),
        .reset          (reset),
        .i_arm          (i_arm),
        .i_abort        (i_abort),
        .i_pre_len      (i_pre_len),
        .i_post_len     (i_post_len),
        .i_holdoff      (i_holdoff),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .i_trig         (i_trig),
        .i_rd_start     (i_rd_start),
        .i_rd_ch        (i_rd_ch),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .i_rd_ready     (i_rd_ready),
        .o_rd_last      (o_rd_last),
        .o_state        (o_state),
        .o_ch_done      (o_ch_done),
        .o_ch_ts        (o_ch_ts),
        .o_ch_len       (o_ch_len),
        .o_overflow     (o_overflow)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } rd_item_t;

    rd_item_t sb_q[$];
    rd_item_t mon_item;
    int n_checks = 0;
    int n_errors = 0;
    int n_xfers  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge adc_clk) begin
        if (!reset && o_rd_valid && i_rd_ready) begin
            n_xfers++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected: got data 0x%0h, expected no transfer", o_rd_data);
            end else begin
                mon_item = sb_q.pop_front();
                check("rd_data", 32'(o_rd_data), 32'(mon_item.data));
                check("rd_last", 32'(o_rd_last), 32'(mon_item.last));
            end
        end
    end

    function automatic logic [7:0] sval(input int k);
        return 8'((k + (k / 256) * 128) & 255);
    endfunction

    function automatic logic [31:0] ch_len(input int c);
        return 32'(o_ch_len[c*LW +: LW]);
    endfunction

    function automatic logic [31:0] ch_ts(input int c);
        return 32'(o_ch_ts[c*TS_W +: TS_W]);
    endfunction

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] v, input logic t);
        i_sample       = v;
        i_sample_valid = 1'b1;
        i_trig         = t;
        tick();
        i_sample_valid = 1'b0;
        i_trig         = 1'b0;
    endtask

    task automatic pulse_arm();
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
    endtask

    task automatic pulse_abort();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int max, input string name);
        int n = 0;
        while (o_state != st && n < max) begin
            tick();
            n++;
        end
        check(name, 32'(o_state), 32'(st));
    endtask

    task automatic read_ch(input int ch, input logic [7:0] vals[$], input bit rnd, input string name);
        int n   = 0;
        int lat = -1;
        int x0;
        rd_item_t it;
        for (int i = 0; i < vals.size(); i++) begin
            it.data = vals[i];
            it.last = (i == vals.size() - 1);
            sb_q.push_back(it);
        end
        x0         = n_xfers;
        i_rd_ch    = CH_W'(ch);
        i_rd_start = 1'b1;
        i_rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        i_rd_start = 1'b0;
        while (o_state != ST_DONE && n < 4000) begin
            if (o_rd_valid && lat < 0) lat = n;
            if (rnd) i_rd_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        i_rd_ready = 1'b0;
        check({name, "_state"}, 32'(o_state), 32'(ST_DONE));
        check({name, "_latency_ok"}, 32'(lat >= 0 && lat <= 1), 32'd1);
        check({name, "_count"}, 32'(n_xfers - x0), 32'(vals.size()));
        check({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vals[$];
        reset = 1'b1;
        i_arm = 1'b0; i_abort = 1'b0; i_sample_valid = 1'b0; i_trig = 1'b0;
        i_rd_start = 1'b0; i_rd_ready = 1'b0; i_rd_ch = '0; i_sample = '0;
        i_pre_len = '0; i_post_len = '0; i_holdoff = '0;
        tick(); tick();
        reset = 1'b0;

        check("rst_state", 32'(o_state), 32'(ST_IDLE));
        check("rst_ch_done", 32'(o_ch_done), 32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        check("rst_rd_data", 32'(o_rd_data), 32'd0);

        // Ramp capture: trigger with sample 100, 16 pre / 64 post.
        i_pre_len = 8'd16; i_post_len = 9'd64; i_holdoff = 8'd0;
        pulse_arm();
        for (int k = 0; k < 300; k++) feed(sval(k), k == 100);
        pulse_abort();
        check("t1_state", 32'(o_state), 32'(ST_DONE));
        check("t1_ch_done", 32'(o_ch_done), 32'h01);
        check("t1_ch_len0", ch_len(0), 32'd80);
        check("t1_ch_ts0", ch_ts(0), 32'd100);
        vals.delete();
        for (int k = 84; k <= 163; k++) vals.push_back(sval(k));
        read_ch(0, vals, 1'b0, "t1_read");

        // Early trigger: only 5 samples of history exist.
        i_pre_len = 8'd16; i_post_len = 9'd10;
        pulse_arm();
        for (int k = 0; k < 5; k++) feed(8'hA0 + 8'(k), 1'b0);
        feed(8'hA5, 1'b1);
        for (int k = 6; k < 15; k++) feed(8'hA0 + 8'(k), 1'b0);
        pulse_abort();
        check("t2_ch_len0", ch_len(0), 32'd15);
        check("t2_ch_ts0", ch_ts(0), 32'd5);
        check("t2_ch_done", 32'(o_ch_done), 32'h01);
        vals.delete();
        for (int k = 0; k < 15; k++) vals.push_back(8'hA0 + 8'(k));
        read_ch(0, vals, 1'b1, "t2_read");

        // Full-depth window that wraps the ring.
        i_pre_len = 8'd200; i_post_len = 9'd200;
        pulse_arm();
        for (int k = 0; k < 306; k++) feed(sval(k), k == 250);
        check("t3_state_holdoff", 32'(o_state), 32'(ST_HOLDOFF));
        pulse_abort();
        check("t3_ch_len0", ch_len(0), 32'd256);
        vals.delete();
        for (int k = 50; k <= 305; k++) vals.push_back(sval(k));
        read_ch(0, vals, 1'b0, "t3_read");

        // All channels, holdoff 10, trig during holdoff, overflow after the last channel.
        i_pre_len = 8'd2; i_post_len = 9'd3; i_holdoff = 8'd10;
        pulse_arm();
        for (int c = 0; c < N_CH; c++) begin
            wait_state(ST_ARMED, 40, "t4_wait_armed");
            for (int j = 0; j < 7; j++) feed(8'(16 * c + j), j == 4);
            if (c == 0) begin
                check("t4_ch_ts0", ch_ts(0), 32'd4);
                i_trig = 1'b1;
                tick();
                i_trig = 1'b0;
                check("t4_holdoff_state", 32'(o_state), 32'(ST_HOLDOFF));
                check("t4_holdoff_trig_ignored", 32'(o_ch_done), 32'h01);
            end
        end
        wait_state(ST_DONE, 40, "t4_wait_done");
        check("t4_ch_done_all", 32'(o_ch_done), 32'h3F);
        check("t4_overflow_pre", 32'(o_overflow), 32'd0);
        i_trig = 1'b1;
        tick();
        i_trig = 1'b0;
        check("t4_overflow", 32'(o_overflow), 32'd1);
        check("t4_state_done", 32'(o_state), 32'(ST_DONE));
        for (int c = 0; c < N_CH; c++) check("t4_ch_len", ch_len(c), 32'd5);
        vals.delete();
        for (int j = 2; j < 7; j++) vals.push_back(8'(16 * 3 + j));
        read_ch(3, vals, 1'b1, "t4_read3");
        vals.delete();
        for (int j = 2; j < 7; j++) vals.push_back(8'(16 * 5 + j));
        read_ch(5, vals, 1'b0, "t4_read5");

        // Abort inside POST leaves the channel incomplete; readout of it is refused.
        i_pre_len = 8'd4; i_post_len = 9'd20; i_holdoff = 8'd0;
        pulse_arm();
        check("t5_overflow_cleared", 32'(o_overflow), 32'd0);
        check("t5_ch_done_cleared", 32'(o_ch_done), 32'd0);
        for (int k = 0; k < 3; k++) feed(8'h10 + 8'(k), 1'b0);
        feed(8'h13, 1'b1);
        feed(8'h14, 1'b0);
        feed(8'h15, 1'b0);
        check("t5_state_post", 32'(o_state), 32'(ST_POST));
        pulse_abort();
        check("t5_state_done", 32'(o_state), 32'(ST_DONE));
        check("t5_ch_done", 32'(o_ch_done), 32'd0);
        i_rd_ch = '0;
        i_rd_start = 1'b1;
        tick();
        i_rd_start = 1'b0;
        tick();
        check("t5_rd_refused_state", 32'(o_state), 32'(ST_DONE));
        check("t5_rd_refused_valid", 32'(o_rd_valid), 32'd0);

        // Reset while a readout is stalled.
        i_pre_len = 8'd0; i_post_len = 9'd8;
        pulse_arm();
        for (int k = 0; k < 8; k++) feed(8'h60 + 8'(k), k == 0);
        pulse_abort();
        check("t6_ch_len0", ch_len(0), 32'd8);
        i_rd_ch = '0;
        i_rd_ready = 1'b0;
        i_rd_start = 1'b1;
        tick();
        i_rd_start = 1'b0;
        for (int n = 0; n < 3 && !o_rd_valid; n++) tick();
        check("t6_rd_valid", 32'(o_rd_valid), 32'd1);
        check("t6_state_read", 32'(o_state), 32'(ST_READ));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_state", 32'(o_state), 32'(ST_IDLE));
        check("t6_rst_rd_valid", 32'(o_rd_valid), 32'd0);
        check("t6_rst_rd_data", 32'(o_rd_data), 32'd0);
        check("t6_rst_ch_done", 32'(o_ch_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/echo_window_recorder.md
ECHO_WINDOW_RECORDER -- requirements
Module: echo_window_recorder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ADC sample width.
REQ-002 SHALL have parameter N_CH, default 6, number of capture channels (2..16).
REQ-003 SHALL have parameter DEPTH, default 256, samples per channel, power of two; AW = log2(DEPTH).
REQ-004 SHALL have parameter TS_W, default 13, timestamp width.
REQ-005 SHALL have ports: adc_clk in 1, clock; reset in 1, synchronous, active-high.
REQ-006 SHALL have control inputs: arm in 1, start pulse; abort in 1, stop pulse; pre_len in AW, pre-trigger samples; post_len in AW+1, post-trigger samples; holdoff in 8, cycles ignored after each window.
REQ-007 SHALL have data inputs: sample in DATA_W; sample_valid in 1; trig in 1, one-cycle echo pulse.
REQ-008 SHALL have readout ports: rd_start in 1; rd_ch in CH_W = clog2(N_CH); rd_data out DATA_W; rd_valid out 1; rd_ready in 1; rd_last out 1.
REQ-009 SHALL have status outputs: state out 3; ch_done out N_CH; ch_ts out N_CH*TS_W; ch_len out N_CH*(AW+1); overflow out 1.

Function
REQ-010 SHALL implement states IDLE, ARMED, POST, HOLDOFF, DONE, READ; encodings 0..5 on state.
REQ-011 SHALL, in IDLE or DONE on arm, clear ch_done/ch_ts/ch_len/overflow, zero ts counter, select channel 0, enter ARMED next cycle.
REQ-012 SHALL, in ARMED, write each valid sample into the current channel's ring (address ch*DEPTH + wptr, wptr wraps mod DEPTH) and count fill, saturating at DEPTH.
REQ-013 SHALL, on trig in ARMED (not the arm cycle), latch ts counter into ch_ts[ch], latch effective pre = min(pre_len, fill), start index = wptr - pre mod DEPTH, enter POST.
REQ-014 SHALL, in POST, write post_eff = min(post_len, DEPTH - pre) valid samples, then set ch_done[ch], ch_len[ch] = pre + post_eff, enter HOLDOFF.
REQ-015 SHALL treat post_eff = 0 as window complete on the trigger cycle.
REQ-016 SHALL stay in HOLDOFF holdoff cycles (0 = one cycle), then advance channel and return to ARMED with fill = 0, or enter DONE after channel N_CH-1.
REQ-017 SHALL ignore trig in POST and HOLDOFF; SHALL set sticky overflow on trig in DONE.
REQ-018 SHALL run ts counter from arm in ARMED/POST/HOLDOFF, +1 per cycle, saturating at 2^TS_W-1.
REQ-019 SHALL, on abort in ARMED/POST/HOLDOFF, enter DONE next cycle; an incomplete channel keeps ch_done = 0.
REQ-020 SHALL, on rd_start in DONE or IDLE with ch_done[rd_ch] = 1, enter READ; otherwise ignore rd_start (arm has priority over rd_start).
REQ-021 SHALL, in READ, stream ch_len[rd_ch] samples oldest first from start index, wrapping mod DEPTH; rd_valid within 2 cycles of rd_start; rd_data/rd_valid held while rd_ready = 0; transfer on rd_valid & rd_ready.
REQ-022 SHALL assert rd_last with the final sample; return to DONE the cycle after its transfer.
REQ-023 SHALL ignore arm and abort during READ.
REQ-024 SHALL ignore samples with sample_valid = 0 for writes and counts.

Reset
REQ-025 SHALL on reset enter IDLE, clear ch_done, ch_ts, ch_len, overflow, rd_valid, rd_last, counters, pointers; rd_data = 0.
REQ-026 SHALL allow reset mid-operation (any state) with effect next cycle; memory contents not cleared.

Structure
REQ-027 SHALL place state encodings and clog2 helper in shared package echo_rec_pkg.
REQ-028 SHALL instantiate one sub-module echo_sample_ram: simple dual-port, N_CH*DEPTH x DATA_W, 1-cycle registered read.
REQ-029 SHALL keep a single adc_clk domain; CDC handled by the instantiating level.

Verification
REQ-030 SHALL cover: arm, 300 ramp samples, trig at sample 100, pre_len 16, post_len 64 -> ch_len[0]=80, readout values 84..163, rd_last on 80th.
REQ-031 SHALL cover: trig 5 samples after arm, pre_len 16 -> pre=5, ch_len=5+post.
REQ-032 SHALL cover: pre_len 200, post_len 200, DEPTH 256 -> post_eff 56, ch_len 256, wrap-correct order.
REQ-033 SHALL cover: N_CH=6 triggers spaced > holdoff, then 7th trig -> all ch_done=1, state DONE, overflow=1; trig inside holdoff 10 -> ignored.
REQ-034 SHALL cover: rd_ready toggled 50% random -> no lost/duplicated samples; abort in POST -> ch_done bit 0, state DONE; reset in READ -> IDLE, rd_valid 0.
